// File: rtl/modsq_job_controller.sv
// Job sequencer between the host start/sq_in/valid interface and a modular-squaring
// engine command/response channel, with tagged results, iteration budget and watchdog.
module modsq_job_controller #(
  parameter int unsigned MOD_LEN     = 1024,
  parameter int unsigned SEQ_LEN     = 4,
  parameter int unsigned ITER_LEN    = 32,
  parameter int unsigned TIMEOUT_LEN = 24,
  parameter int unsigned STALE_LEN   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [MOD_LEN-1:0]     sq_in,
  input  logic [ITER_LEN-1:0]    iter_count,
  input  logic [TIMEOUT_LEN-1:0] timeout_limit,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_flush,
  output logic [SEQ_LEN-1:0]     cmd_seq,
  output logic [MOD_LEN-1:0]     cmd_data,
  input  logic                   rsp_valid,
  output logic                   rsp_ready,
  input  logic [SEQ_LEN-1:0]     rsp_seq,
  input  logic [MOD_LEN-1:0]     rsp_data,
  output logic [MOD_LEN-1:0]     sq_out,
  output logic                   valid,
  output logic                   done,
  output logic                   busy,
  output logic                   timeout,
  output logic [STALE_LEN-1:0]   stale_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_LOAD, S_RUN} state_t;

  state_t                 r_state, w_next_state;
  logic [SEQ_LEN-1:0]     r_cur_seq;
  logic                   r_pend_start, r_pend_abort;
  logic [MOD_LEN-1:0]     r_op;
  logic [ITER_LEN-1:0]    r_remaining;
  logic [TIMEOUT_LEN-1:0] r_wd;
  logic                   r_cmd_valid, r_cmd_flush;
  logic [SEQ_LEN-1:0]     r_cmd_seq;
  logic [MOD_LEN-1:0]     r_cmd_data;
  logic [MOD_LEN-1:0]     r_sq_out;
  logic                   r_valid, r_done, r_busy, r_timeout;
  logic [STALE_LEN-1:0]   r_stale;

  logic                   w_hs, w_accept, w_last, w_wd_fire;
  logic [SEQ_LEN-1:0]     w_next_seq, w_cur_seq_nxt;
  logic [TIMEOUT_LEN-1:0] w_wd_inc;
  logic                   w_adv, w_done, w_set_to;
  logic                   w_pend_start_nxt, w_pend_abort_nxt;
  logic                   w_new_flush, w_new_load;

  assign w_hs       = r_cmd_valid & cmd_ready;
  assign w_accept   = rsp_valid & (r_state == S_RUN) & (rsp_seq == r_cur_seq) & (r_cur_seq != '0);
  assign w_last     = w_accept & (r_remaining == ITER_LEN'(1));
  assign w_wd_inc   = r_wd + TIMEOUT_LEN'(1);
  assign w_wd_fire  = (r_state == S_RUN) & ~w_accept & (timeout_limit != '0) & (w_wd_inc == timeout_limit);
  // Tag 0 is reserved, so the increment wraps from all-ones back to 1.
  assign w_next_seq = (r_cur_seq == '1) ? SEQ_LEN'(1) : r_cur_seq + SEQ_LEN'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state     = r_state;
    w_pend_start_nxt = r_pend_start;
    w_pend_abort_nxt = r_pend_abort;
    w_adv            = start | abort;
    w_done           = 1'b0;
    w_set_to         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FLUSH;
      end
      S_FLUSH, S_LOAD: begin
        // The offered command must complete; start/abort are deferred to its handshake.
        if (start) begin
          w_pend_start_nxt = 1'b1;
          w_pend_abort_nxt = 1'b0;
        end else if (abort) begin
          w_pend_start_nxt = 1'b0;
          w_pend_abort_nxt = 1'b1;
        end
        if (w_hs) begin
          if (w_pend_start_nxt)      w_next_state = S_FLUSH;
          else if (w_pend_abort_nxt) w_next_state = S_IDLE;
          else if (r_state == S_FLUSH) w_next_state = S_LOAD;
          else                       w_next_state = S_RUN;
          w_pend_start_nxt = 1'b0;
          w_pend_abort_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (start)      w_next_state = S_FLUSH;
        else if (abort) w_next_state = S_IDLE;
        else if (w_last) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else if (w_wd_fire) begin
          w_set_to     = 1'b1;
          w_adv        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_cur_seq_nxt = w_adv ? w_next_seq : r_cur_seq;
  assign w_new_flush   = (w_next_state == S_FLUSH) & ((r_state != S_FLUSH) | w_hs);
  assign w_new_load    = (w_next_state == S_LOAD) & (r_state != S_LOAD);

  // Command channel, job context and tag tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_seq    <= '0;
      r_pend_start <= 1'b0;
      r_pend_abort <= 1'b0;
      r_op         <= '0;
      r_remaining  <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_flush  <= 1'b0;
      r_cmd_seq    <= '0;
      r_cmd_data   <= '0;
    end else begin
      r_cur_seq    <= w_cur_seq_nxt;
      r_pend_start <= w_pend_start_nxt;
      r_pend_abort <= w_pend_abort_nxt;
      r_cmd_valid  <= (w_next_state == S_FLUSH) | (w_next_state == S_LOAD);
      if (w_new_flush) begin
        r_cmd_flush <= 1'b1;
        r_cmd_seq   <= w_cur_seq_nxt;
      end else if (w_new_load) begin
        r_cmd_flush <= 1'b0;
        r_cmd_data  <= r_op;
      end
      if (start) begin
        r_op        <= sq_in;
        r_remaining <= iter_count;
      end else if (w_accept && (r_remaining != '0)) begin
        r_remaining <= r_remaining - ITER_LEN'(1);
      end
    end
  end

  // Result path, status flags, stale counter and watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sq_out  <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_stale   <= '0;
      r_wd      <= '0;
    end else begin
      r_valid <= w_accept;
      r_done  <= w_done;
      r_busy  <= (w_next_state != S_IDLE);
      if (w_accept) r_sq_out <= rsp_data;
      if (start)         r_timeout <= 1'b0;
      else if (w_set_to) r_timeout <= 1'b1;
      if (rsp_valid && !w_accept && (r_stale != '1)) r_stale <= r_stale + STALE_LEN'(1);
      if ((r_state != S_RUN) || w_accept) r_wd <= '0;
      else                                r_wd <= w_wd_inc;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_flush = r_cmd_flush;
  assign cmd_seq   = r_cmd_seq;
  assign cmd_data  = r_cmd_data;
  assign rsp_ready = 1'b1;
  assign sq_out    = r_sq_out;
  assign valid     = r_valid;
  assign done      = r_done;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign stale_cnt = r_stale;

endmodule

// File: tb/tb_modsq_job_controller.sv
// Directed bench for modsq_job_controller: per-cycle vector table for a basic job,
// then hand sequences for backpressure, tag wrap, watchdog, unlimited runs, abort and reset.
module tb_modsq_job_controller;

  localparam int unsigned MOD_LEN     = 16;
  localparam int unsigned SEQ_LEN     = 2;
  localparam int unsigned ITER_LEN    = 8;
  localparam int unsigned TIMEOUT_LEN = 8;
  localparam int unsigned STALE_LEN   = 2;

  logic                   clk = 1'b0;
  logic                   reset, start, abort, cmd_ready, rsp_valid;
  logic [MOD_LEN-1:0]     sq_in, rsp_data;
  logic [ITER_LEN-1:0]    iter_count;
  logic [TIMEOUT_LEN-1:0] timeout_limit;
  logic [SEQ_LEN-1:0]     rsp_seq;
  logic                   cmd_valid, cmd_flush, rsp_ready, valid, done, busy, timeout;
  logic [SEQ_LEN-1:0]     cmd_seq;
  logic [MOD_LEN-1:0]     cmd_data, sq_out;
  logic [STALE_LEN-1:0]   stale_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  modsq_job_controller #(
    .MOD_LEN(MOD_LEN), .SEQ_LEN(SEQ_LEN), .ITER_LEN(ITER_LEN),
    .TIMEOUT_LEN(TIMEOUT_LEN), .STALE_LEN(STALE_LEN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .sq_in(sq_in),
    .iter_count(iter_count), .timeout_limit(timeout_limit),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_flush(cmd_flush),
    .cmd_seq(cmd_seq), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_seq(rsp_seq), .rsp_data(rsp_data),
    .sq_out(sq_out), .valid(valid), .done(done), .busy(busy),
    .timeout(timeout), .stale_cnt(stale_cnt)
  );

  typedef struct {
    logic        start;
    logic [15:0] sq;
    logic [7:0]  iter;
    logic        ready;
    logic        rv;
    logic [1:0]  rs;
    logic [15:0] rd;
    logic        cv, cf;
    logic [1:0]  cs;
    logic [15:0] cdata;
    logic        val;
    logic [15:0] out;
    logic        dn, bsy;
    logic [1:0]  stale;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic st, input logic [15:0] sq, input logic [7:0] it,
                              input logic rdy, input logic rv, input logic [1:0] rs,
                              input logic [15:0] rd, input logic cv, input logic cf,
                              input logic [1:0] cs, input logic [15:0] cdata, input logic val,
                              input logic [15:0] out, input logic dn, input logic bsy,
                              input logic [1:0] stale);
    vec_t v;
    v.start = st; v.sq = sq; v.iter = it; v.ready = rdy; v.rv = rv; v.rs = rs; v.rd = rd;
    v.cv = cv; v.cf = cf; v.cs = cs; v.cdata = cdata; v.val = val; v.out = out;
    v.dn = dn; v.bsy = bsy; v.stale = stale;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; sq_in = '0; iter_count = '0;
    rsp_valid = 1'b0; rsp_seq = '0; rsp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] sq, input logic [7:0] it);
    start = 1'b1; sq_in = sq; iter_count = it;
    tick();
    start = 1'b0;
  endtask

  task automatic send_rsp(input logic [1:0] s, input logic [15:0] d);
    rsp_valid = 1'b1; rsp_seq = s; rsp_data = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  initial begin
    int n, vc, dc;
    logic [1:0] exp_tags[5];

    idle_inputs();
    cmd_ready = 1'b0;
    timeout_limit = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_seq", 32'(cmd_seq), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_stale", 32'(stale_cnt), 0);
    chk("rst_sq_out", 32'(sq_out), 0);
    chk("rst_rsp_ready", 32'(rsp_ready), 1);
    reset = 1'b0;

    // Basic 3-result job, stale tags, stale saturation.
    //             st sq    it rdy rv rs rd       cv cf cs cdata val out     dn bsy stale
    vecs[0]  = mk(1, 16'h5, 3, 1, 0, 0, 16'h0,   1, 1, 1, 16'h0, 0, 16'h0,  0, 1, 0);
    vecs[1]  = mk(0, 16'h0, 0, 1, 0, 0, 16'h0,   1, 0, 1, 16'h5, 0, 16'h0,  0, 1, 0);
    vecs[2]  = mk(0, 16'h0, 0, 1, 0, 0, 16'h0,   0, 0, 1, 16'h5, 0, 16'h0,  0, 1, 0);
    vecs[3]  = mk(0, 16'h0, 0, 1, 1, 1, 16'h11,  0, 0, 1, 16'h5, 1, 16'h11, 0, 1, 0);
    vecs[4]  = mk(0, 16'h0, 0, 1, 1, 0, 16'h22,  0, 0, 1, 16'h5, 0, 16'h11, 0, 1, 1);
    vecs[5]  = mk(0, 16'h0, 0, 1, 1, 2, 16'h23,  0, 0, 1, 16'h5, 0, 16'h11, 0, 1, 2);
    vecs[6]  = mk(0, 16'h0, 0, 1, 1, 1, 16'h33,  0, 0, 1, 16'h5, 1, 16'h33, 0, 1, 2);
    vecs[7]  = mk(0, 16'h0, 0, 1, 0, 0, 16'h0,   0, 0, 1, 16'h5, 0, 16'h33, 0, 1, 2);
    vecs[8]  = mk(0, 16'h0, 0, 1, 1, 1, 16'h44,  0, 0, 1, 16'h5, 1, 16'h44, 1, 0, 2);
    vecs[9]  = mk(0, 16'h0, 0, 1, 1, 1, 16'h55,  0, 0, 1, 16'h5, 0, 16'h44, 0, 0, 3);
    vecs[10] = mk(0, 16'h0, 0, 1, 1, 3, 16'h56,  0, 0, 1, 16'h5, 0, 16'h44, 0, 0, 3);
    vecs[11] = mk(0, 16'h0, 0, 1, 1, 1, 16'h57,  0, 0, 1, 16'h5, 0, 16'h44, 0, 0, 3);
    vecs[12] = mk(0, 16'h0, 0, 1, 1, 2, 16'h58,  0, 0, 1, 16'h5, 0, 16'h44, 0, 0, 3);

    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start; sq_in = vecs[i].sq; iter_count = vecs[i].iter;
      cmd_ready = vecs[i].ready; rsp_valid = vecs[i].rv; rsp_seq = vecs[i].rs;
      rsp_data = vecs[i].rd;
      tick();
      chk($sformatf("v%0d_cmd_valid", i), 32'(cmd_valid), 32'(vecs[i].cv));
      chk($sformatf("v%0d_cmd_flush", i), 32'(cmd_flush), 32'(vecs[i].cf));
      chk($sformatf("v%0d_cmd_seq", i), 32'(cmd_seq), 32'(vecs[i].cs));
      chk($sformatf("v%0d_cmd_data", i), 32'(cmd_data), 32'(vecs[i].cdata));
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].val));
      chk($sformatf("v%0d_sq_out", i), 32'(sq_out), 32'(vecs[i].out));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("v%0d_stale", i), 32'(stale_cnt), 32'(vecs[i].stale));
    end
    idle_inputs();

    // Backpressure in FLUSH with a restart mid-wait: command held, then retagged.
    do_reset();
    cmd_ready = 1'b0;
    pulse_start(16'h7, 0);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin start = 1'b1; sq_in = 16'h9; end
      tick();
      start = 1'b0;
      chk("bp_cmd_valid", 32'(cmd_valid), 1);
      chk("bp_cmd_flush", 32'(cmd_flush), 1);
      chk("bp_cmd_seq_held", 32'(cmd_seq), 1);
    end
    cmd_ready = 1'b1;
    tick();
    chk("bp_reflush_valid", 32'(cmd_valid), 1);
    chk("bp_reflush_flush", 32'(cmd_flush), 1);
    chk("bp_reflush_seq", 32'(cmd_seq), 2);
    tick();
    chk("bp_load_flush", 32'(cmd_flush), 0);
    chk("bp_load_data", 32'(cmd_data), 32'h9);
    tick();
    cmd_ready = 1'b0;
    chk("bp_run_cmd_valid", 32'(cmd_valid), 0);
    send_rsp(1, 16'hAA);
    chk("bp_old_tag_valid", 32'(valid), 0);
    chk("bp_old_tag_stale", 32'(stale_cnt), 1);
    send_rsp(2, 16'hAB);
    chk("bp_new_tag_valid", 32'(valid), 1);
    chk("bp_new_tag_out", 32'(sq_out), 32'hAB);

    // Tag sequence with SEQ_LEN=2 skips the reserved 0.
    do_reset();
    cmd_ready = 1'b1;
    exp_tags[0] = 2'd1; exp_tags[1] = 2'd2; exp_tags[2] = 2'd3;
    exp_tags[3] = 2'd1; exp_tags[4] = 2'd2;
    for (int i = 0; i < 5; i++) begin
      pulse_start(16'h1, 0);
      chk($sformatf("wrap_seq%0d", i), 32'(cmd_seq), 32'(exp_tags[i]));
      chk($sformatf("wrap_flush%0d", i), 32'(cmd_flush), 1);
      tick();
      tick();
    end

    // Watchdog fires 8 cycles after entering RUN.
    do_reset();
    timeout_limit = 8'd8;
    cmd_ready = 1'b1;
    pulse_start(16'h3, 0);
    tick();
    tick();
    cmd_ready = 1'b0;
    n = 0;
    while (timeout == 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("wd_cycles", 32'(n), 8);
    chk("wd_timeout", 32'(timeout), 1);
    chk("wd_busy", 32'(busy), 0);
    send_rsp(1, 16'h5A);
    chk("wd_late_valid", 32'(valid), 0);
    chk("wd_late_stale", 32'(stale_cnt), 1);
    pulse_start(16'h3, 0);
    chk("wd_start_clears", 32'(timeout), 0);
    chk("wd_restart_seq", 32'(cmd_seq), 3);
    timeout_limit = '0;

    // Unlimited budget: 100 results, no done; then abort.
    do_reset();
    cmd_ready = 1'b1;
    pulse_start(16'h2, 0);
    tick();
    tick();
    vc = 0;
    dc = 0;
    for (int i = 1; i <= 100; i++) begin
      rsp_valid = 1'b1; rsp_seq = 2'd1; rsp_data = 16'(i);
      tick();
      if (valid === 1'b1 && sq_out === 16'(i)) vc++;
      if (done === 1'b1) dc++;
    end
    rsp_valid = 1'b0;
    chk("unl_valid_pulses", 32'(vc), 100);
    chk("unl_done_pulses", 32'(dc), 0);
    chk("unl_busy", 32'(busy), 1);
    chk("unl_stale", 32'(stale_cnt), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cmd_valid", 32'(cmd_valid), 0);
    send_rsp(1, 16'h99);
    chk("abort_old_valid", 32'(valid), 0);
    chk("abort_old_stale", 32'(stale_cnt), 1);
    send_rsp(2, 16'h98);
    chk("abort_idle_stale", 32'(stale_cnt), 2);

    // Reset while a LOAD command is stalled.
    cmd_ready = 1'b1;
    pulse_start(16'h77, 2);
    tick();
    cmd_ready = 1'b0;
    chk("rl_pre_cmd_valid", 32'(cmd_valid), 1);
    chk("rl_pre_cmd_flush", 32'(cmd_flush), 0);
    chk("rl_pre_cmd_data", 32'(cmd_data), 32'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rl_cmd_valid", 32'(cmd_valid), 0);
    chk("rl_cmd_flush", 32'(cmd_flush), 0);
    chk("rl_cmd_seq", 32'(cmd_seq), 0);
    chk("rl_cmd_data", 32'(cmd_data), 0);
    chk("rl_sq_out", 32'(sq_out), 0);
    chk("rl_busy", 32'(busy), 0);
    chk("rl_stale", 32'(stale_cnt), 0);
    send_rsp(0, 16'h42);
    chk("rl_tag0_valid", 32'(valid), 0);
    chk("rl_tag0_stale", 32'(stale_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modsq_job_controller.md
Name: modsq_job_controller

Overview:
- Single-clock job sequencer in the clk domain, between the host start/sq_in/valid interface and a modular-squaring engine reached through a command/response channel (clock-crossing FIFOs sit outside this block).
- Successor to the fixed-tag start/reset latch. Adds:
  - parametrised sequence-tag width;
  - a reserved invalid tag;
  - an iteration budget with a done pulse;
  - a stale-result counter;
  - a result watchdog;
  - host abort.

Parameters:
- MOD_LEN, 1024, operand/result width in bits.
- SEQ_LEN, 4, sequence-tag width; tag 0 is reserved as invalid.
- ITER_LEN, 32, width of the iteration budget.
- TIMEOUT_LEN, 24, watchdog counter width.
- STALE_LEN, 16, stale-result counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  1-cycle pulse: begin new job.
- abort  in  1  1-cycle pulse: cancel current job.
- sq_in  in  MOD_LEN  initial value, sampled with start.
- iter_count  in  ITER_LEN  results to deliver, sampled with start; 0 means unlimited.
- timeout_limit  in  TIMEOUT_LEN  watchdog limit in cycles; 0 disables the watchdog.
- cmd_valid  out  1  command offered to engine.
- cmd_ready  in  1  engine accepts command.
- cmd_flush  out  1  1 = flush/retag command, 0 = start command.
- cmd_seq  out  SEQ_LEN  tag carried by the command.
- cmd_data  out  MOD_LEN  start operand.
- rsp_valid  in  1  engine result available.
- rsp_ready  out  1  result consumed; tied to 1.
- rsp_seq  in  SEQ_LEN  tag of the result.
- rsp_data  in  MOD_LEN  result value.
- sq_out  out  MOD_LEN  accepted result.
- valid  out  1  sq_out valid, 1-cycle pulse.
- done  out  1  1-cycle pulse when the budget is exhausted.
- busy  out  1  state != IDLE.
- timeout  out  1  sticky; cleared by start or reset.
- stale_cnt  out  STALE_LEN  saturating count of dropped results.

Behaviour:
- Reset values:
  - state = IDLE; cur_seq = 0; cmd_seq = 0.
  - cmd_valid, valid, done, busy, timeout = 0.
  - stale_cnt = 0; sq_out = 0; pending_start = 0.
- Tag advance: next = cur_seq + 1 modulo 2^SEQ_LEN, skipping 0 (max wraps to 1).
- States: IDLE, FLUSH, LOAD, RUN. Outputs per state:
  - IDLE: cmd_valid = 0.
  - FLUSH: cmd_valid = 1, cmd_flush = 1, cmd_seq = job tag.
  - LOAD: cmd_valid = 1, cmd_flush = 0, cmd_data = latched sq_in.
  - RUN: cmd_valid = 0.
- Transitions:
  - FLUSH -> LOAD on cmd_valid & cmd_ready.
  - LOAD -> RUN on handshake.
- Command stability: cmd_flush, cmd_seq and cmd_data are stable while cmd_valid = 1 and cmd_ready = 0.
- start (any state):
  - cur_seq advances immediately; sq_in and iter_count are latched into remaining; timeout clears.
  - From IDLE or RUN: next state FLUSH with cmd_seq = new cur_seq.
  - From FLUSH or LOAD: the in-progress command completes unchanged; pending_start is set; after its handshake the state goes to FLUSH with the new tag (the latest start wins).
- abort:
  - cur_seq advances; pending_start clears.
  - An in-progress command handshake completes first, then the state goes to IDLE.
  - From RUN: straight to IDLE, no command issued.
- start and abort in the same cycle: start wins.
- Results: rsp_ready = 1 in every state, so the engine is always drained.
- Result acceptance: a result is accepted iff rsp_valid & state == RUN & rsp_seq == cur_seq & cur_seq != 0.
  - On acceptance: sq_out <= rsp_data and valid = 1 on the next cycle (1-cycle latency).
  - If remaining != 0, remaining decrements.
  - When an accepted result takes remaining from 1 to 0: done pulses together with valid, and state -> IDLE.
- Stale results: any other rsp_valid increments stale_cnt, saturating at all-ones. This includes results arriving in IDLE, FLUSH or LOAD.
- Watchdog:
  - A cycle counter runs in RUN and clears on each accepted result and on entry to RUN.
  - If timeout_limit != 0 and the counter reaches timeout_limit: timeout <= 1, cur_seq advances, state -> IDLE.
- reset mid-operation:
  - All state returns to reset values; cmd_valid drops the next cycle. (The engine side tolerates a dropped command because it is reset via the host path.)
  - cur_seq = 0, so no result is accepted until the next start.

Test Plan:
- Reset, start with sq_in=5, iter_count=3, cmd_ready=1 -> flush (seq=1) and then load (data=5) commands on consecutive cycles. Three results tagged 1 -> three valid pulses one cycle after each result; done on the 3rd; busy falls.
- Results tagged 0 and 2 while cur_seq=1 -> no valid; stale_cnt=2. With STALE_LEN=2 and 5 stale results -> stale_cnt saturates at 3.
- cmd_ready held 0 for 10 cycles in FLUSH, start pulsed mid-wait -> cmd_seq stays 1 until handshake; then a new flush with seq=2; results tagged 1 afterwards are counted stale.
- SEQ_LEN=2, five successive starts -> tags 1,2,3,1,2 (0 never issued).
- timeout_limit=8 in RUN, no results -> timeout=1 after 8 cycles; state IDLE; a late result with the old tag is counted stale. Next start clears timeout.
- iter_count=0, 100 results -> 100 valid pulses, no done. abort -> IDLE within 1 cycle; further results are counted stale. reset during LOAD -> cmd_valid=0 the next cycle, all outputs at reset values.
